// File: rtl/sparhixcel_mem_loader_if.sv
// Host/DMA stream handshake into the preload memory loader.
// Beats move on s_valid_i && s_ready_o.
interface sparhixcel_mem_loader_if #(
    parameter int IN_WIDTH = 32
);
    logic [IN_WIDTH-1:0] s_data_i;
    logic                s_valid_i;
    logic                s_ready_o;

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o
    );

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o
    );
endinterface

// File: rtl/sparhixcel_mem_loader.sv
// Packet-driven writer for the feature, weight and signal-ROM memories.
// Assembles 32-bit beats into full words and strobes one write per word.
module sparhixcel_mem_loader #(
    parameter int IN_WIDTH       = 32,
    parameter int N_ROWS_ARRAY   = 16,
    parameter int I_WIDTH        = 8,
    parameter int F_WIDTH        = 8,
    parameter int ROM_SIG_WIDTH  = 144,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int SIG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      general_rst_ni,
    sparhixcel_mem_loader_if.slave    s_if,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addrs_mem_o,
    output logic                      wr_mem_ld_o,
    output logic [N_ROWS_ARRAY*I_WIDTH-1:0] mem_data_o,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addrs_mem2_o,
    output logic                      wr_mem2_ld_o,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0] mem2_data_o,
    output logic [SIG_ADDR_WIDTH-1:0] wr_addrs_rom_signal_o,
    output logic                      wr_rom_signals_ld_o,
    output logic [ROM_SIG_WIDTH-1:0]  rom_signals_data_o,
    output logic                      busy_o,
    output logic                      load_done_o,
    output logic                      err_o
);
    localparam int FW    = N_ROWS_ARRAY * I_WIDTH;
    localparam int WW    = N_ROWS_ARRAY * F_WIDTH;
    localparam int FBPW  = (FW + IN_WIDTH - 1) / IN_WIDTH;
    localparam int WBPW  = (WW + IN_WIDTH - 1) / IN_WIDTH;
    localparam int RBPW  = (ROM_SIG_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int MAXFW = (FBPW > WBPW) ? FBPW : WBPW;
    localparam int MAXB  = (RBPW > MAXFW) ? RBPW : MAXFW;
    localparam int ASM_W = MAXB * IN_WIDTH;
    localparam int BW    = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int RSV_BPW = 4;

    localparam logic [1:0] TGT_FEAT = 2'b00;
    localparam logic [1:0] TGT_WGT  = 2'b01;
    localparam logic [1:0] TGT_ROM  = 2'b10;
    localparam logic [1:0] TGT_RSV  = 2'b11;

    typedef enum logic [1:0] {
        S_HDR0, S_HDR1, S_PAY, S_WR
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [1:0]                  r_tgt;
    logic [MEM_ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]                 r_cnt;
    logic [BW-1:0]               r_beat;
    logic [ASM_W-1:0]            r_asm;
    logic                        r_done;
    logic                        r_err;
    logic [MEM_ADDR_WIDTH-1:0]   r_mem_addr;
    logic [FW-1:0]               r_mem_data;
    logic [MEM_ADDR_WIDTH-1:0]   r_mem2_addr;
    logic [WW-1:0]               r_mem2_data;
    logic [SIG_ADDR_WIDTH-1:0]   r_rom_addr;
    logic [ROM_SIG_WIDTH-1:0]    r_rom_data;

    logic                        w_acc;
    logic                        w_last;
    logic [BW-1:0]               w_last_idx;
    logic [ASM_W-1:0]            w_word;

    assign w_acc  = s_if.s_valid_i && s_if.s_ready_o;
    assign w_last = (r_beat == w_last_idx);

    // Reserved packets are drained at the feature-word beat rate.
    always_comb begin
        unique case (r_tgt)
            TGT_FEAT: w_last_idx = BW'(FBPW - 1);
            TGT_WGT:  w_last_idx = BW'(WBPW - 1);
            TGT_ROM:  w_last_idx = BW'(RBPW - 1);
            default:  w_last_idx = BW'(RSV_BPW - 1);
        endcase
    end

    // Current beat merged in so the word is complete on the last accept.
    always_comb begin
        w_word = r_asm;
        for (int k = 0; k < MAXB; k++) begin
            if (r_beat == BW'(k))
                w_word[k*IN_WIDTH +: IN_WIDTH] = s_if.s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) r_state <= S_HDR0;
        else                 r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR0: if (w_acc) w_next = S_HDR1;
            S_HDR1: if (w_acc) w_next = S_PAY;
            S_PAY:  if (w_acc && w_last) w_next = S_WR;
            S_WR:   w_next = (r_cnt == '0) ? S_HDR0 : S_PAY;
            default: w_next = S_HDR0;
        endcase
    end

    always_comb begin
        s_if.s_ready_o      = general_rst_ni && (r_state != S_WR);
        busy_o              = (r_state != S_HDR0) || r_done;
        wr_mem_ld_o         = (r_state == S_WR) && (r_tgt == TGT_FEAT);
        wr_mem2_ld_o        = (r_state == S_WR) && (r_tgt == TGT_WGT);
        wr_rom_signals_ld_o = (r_state == S_WR) && (r_tgt == TGT_ROM);
    end

    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            r_tgt       <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_asm       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem2_addr <= '0;
            r_mem2_data <= '0;
            r_rom_addr  <= '0;
            r_rom_data  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_HDR0: if (w_acc) begin
                    r_tgt  <= s_if.s_data_i[31:30];
                    r_addr <= s_if.s_data_i[MEM_ADDR_WIDTH-1:0];
                    r_beat <= '0;
                    if (s_if.s_data_i[31:30] == TGT_RSV) r_err <= 1'b1;
                end
                S_HDR1: if (w_acc) r_cnt <= s_if.s_data_i[15:0];
                S_PAY: if (w_acc) begin
                    r_asm <= w_word;
                    if (w_last) begin
                        r_beat <= '0;
                        unique case (r_tgt)
                            TGT_FEAT: begin
                                r_mem_addr <= r_addr;
                                r_mem_data <= w_word[FW-1:0];
                            end
                            TGT_WGT: begin
                                r_mem2_addr <= r_addr;
                                r_mem2_data <= w_word[WW-1:0];
                            end
                            TGT_ROM: begin
                                r_rom_addr <= r_addr[SIG_ADDR_WIDTH-1:0];
                                r_rom_data <= w_word[ROM_SIG_WIDTH-1:0];
                            end
                            default: ;
                        endcase
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_WR: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_cnt == '0) r_done <= (r_tgt != TGT_RSV);
                    else             r_cnt  <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_addrs_mem_o        = r_mem_addr;
    assign mem_data_o            = r_mem_data;
    assign wr_addrs_mem2_o       = r_mem2_addr;
    assign mem2_data_o           = r_mem2_data;
    assign wr_addrs_rom_signal_o = r_rom_addr;
    assign rom_signals_data_o    = r_rom_data;
    assign load_done_o           = r_done;
    assign err_o                 = r_err;
endmodule

// File: tb/tb_sparhixcel_mem_loader.sv
// Directed bench for the preload memory loader.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sparhixcel_mem_loader;
    logic         clk;
    logic         rst_n;
    logic [15:0]  a_mem, a_mem2;
    logic [4:0]   a_rom;
    logic         ld_mem, ld_mem2, ld_rom;
    logic [127:0] d_mem, d_mem2;
    logic [143:0] d_rom;
    logic         busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [1:0]   port;
        logic [15:0]  addr;
        logic [143:0] data;
        int           cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    wr_t mon_e;
    bit  rdy_chk = 0;
    bit  busy_chk = 0;
    int  rdy_viol = 0;
    int  busy_low = 0;

    sparhixcel_mem_loader_if sif ();

    sparhixcel_mem_loader dut (
        .clk_i                 (clk),
        .general_rst_ni        (rst_n),
        .s_if                  (sif.slave),
        .wr_addrs_mem_o        (a_mem),
        .wr_mem_ld_o           (ld_mem),
        .mem_data_o            (d_mem),
        .wr_addrs_mem2_o       (a_mem2),
        .wr_mem2_ld_o          (ld_mem2),
        .mem2_data_o           (d_mem2),
        .wr_addrs_rom_signal_o (a_rom),
        .wr_rom_signals_ld_o   (ld_rom),
        .rom_signals_data_o    (d_rom),
        .busy_o                (busy),
        .load_done_o           (done),
        .err_o                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ld_mem) begin
                mon_e.port = 2'd0; mon_e.addr = a_mem;
                mon_e.data = {16'h0, d_mem}; mon_e.cyc = cyc;
                wq.push_back(mon_e);
            end
            if (ld_mem2) begin
                mon_e.port = 2'd1; mon_e.addr = a_mem2;
                mon_e.data = {16'h0, d_mem2}; mon_e.cyc = cyc;
                wq.push_back(mon_e);
            end
            if (ld_rom) begin
                mon_e.port = 2'd2; mon_e.addr = {11'h0, a_rom};
                mon_e.data = d_rom; mon_e.cyc = cyc;
                wq.push_back(mon_e);
            end
            if (done) dq.push_back(cyc);
            if (rdy_chk && ((ld_mem | ld_mem2 | ld_rom) == sif.s_ready_o))
                rdy_viol++;
            if (busy_chk && !busy) busy_low++;
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        sif.s_valid_i = 1'b1;
        sif.s_data_i  = d;
        while (!sif.s_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: beat %h never accepted", d);
        end
        @(negedge clk);
        sif.s_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (dq.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clear_q();
        wq.delete();
        dq.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({ld_mem, ld_mem2, ld_rom, done, err, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {ld_mem, ld_mem2, ld_rom, done, err, busy});
        end
        checks++;
        if ({a_mem, a_mem2, a_rom} !== 37'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0",
                     {a_mem, a_mem2, a_rom});
        end
        checks++;
        if ({d_mem, d_mem2, d_rom} !== 400'h0) begin
            errors++;
            $display("FAIL reset_data: nonzero data outputs");
        end
        checks++;
        if (sif.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", sif.s_ready_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sif.s_ready_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_busy: got %b%b expected 10",
                     sif.s_ready_o, busy);
        end
    endtask

    task automatic test_feature();
        clear_q();
        send(32'h0000_0010);
        send(32'h0000_0001);
        for (int i = 1; i <= 8; i++) send(i);
        checks++;
        if (ld_mem !== 1'b1 || sif.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL feat_latency: ld=%b rdy=%b expected 1 0",
                     ld_mem, sif.s_ready_o);
        end
        wait_done(1);
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL feat_count: got %0d expected 2", wq.size());
        end
        checks++;
        if (wq[0].port !== 2'd0 || wq[0].addr !== 16'h0010 ||
            wq[0].data !== 144'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL feat_w0: got p%0d a%h d%h expected p0 a0010",
                     wq[0].port, wq[0].addr, wq[0].data);
        end
        checks++;
        if (wq[1].port !== 2'd0 || wq[1].addr !== 16'h0011 ||
            wq[1].data !== 144'h00000008_00000007_00000006_00000005) begin
            errors++;
            $display("FAIL feat_w1: got p%0d a%h d%h expected p0 a0011",
                     wq[1].port, wq[1].addr, wq[1].data);
        end
        checks++;
        if (wq[1].cyc - wq[0].cyc != 5) begin
            errors++;
            $display("FAIL feat_rate: got %0d expected 5",
                     wq[1].cyc - wq[0].cyc);
        end
        checks++;
        if (dq.size() != 1 || dq[0] != wq[1].cyc + 1) begin
            errors++;
            $display("FAIL feat_done: got n=%0d c=%0d expected n=1 c=%0d",
                     dq.size(), dq[0], wq[1].cyc + 1);
        end
    endtask

    task automatic test_rom();
        clear_q();
        send(32'h8000_001F);
        send(32'h0000_0001);
        for (int i = 1; i <= 10; i++)
            send({8'hB0, 8'(i), 8'h5A, 8'(i)});
        wait_done(1);
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL rom_count: got %0d expected 2", wq.size());
        end
        checks++;
        if (wq[0].port !== 2'd2 || wq[0].addr !== 16'd31 ||
            wq[0].data !== {16'h5A05, 32'hB0045A04, 32'hB0035A03,
                            32'hB0025A02, 32'hB0015A01}) begin
            errors++;
            $display("FAIL rom_w0: got p%0d a%0d d%h expected p2 a31",
                     wq[0].port, wq[0].addr, wq[0].data);
        end
        checks++;
        if (wq[1].port !== 2'd2 || wq[1].addr !== 16'd0 ||
            wq[1].data !== {16'h5A0A, 32'hB0095A09, 32'hB0085A08,
                            32'hB0075A07, 32'hB0065A06}) begin
            errors++;
            $display("FAIL rom_w1: got p%0d a%0d d%h expected p2 a0",
                     wq[1].port, wq[1].addr, wq[1].data);
        end
        checks++;
        if (wq[1].cyc - wq[0].cyc != 6) begin
            errors++;
            $display("FAIL rom_rate: got %0d expected 6",
                     wq[1].cyc - wq[0].cyc);
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        rdy_viol = 0;
        rdy_chk = 1;
        send(32'h4000_0100);
        send(32'h0000_0002);
        for (int i = 1; i <= 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(32'h1000_0000 + i);
        end
        wait_done(1);
        rdy_chk = 0;
        checks++;
        if (wq.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 3", wq.size());
        end
        checks++;
        if (wq[0].port !== 2'd1 || wq[0].addr !== 16'h0100 ||
            wq[0].data !== 144'h10000004_10000003_10000002_10000001) begin
            errors++;
            $display("FAIL bp_w0: got p%0d a%h d%h", wq[0].port,
                     wq[0].addr, wq[0].data);
        end
        checks++;
        if (wq[1].port !== 2'd1 || wq[1].addr !== 16'h0101 ||
            wq[1].data !== 144'h10000008_10000007_10000006_10000005) begin
            errors++;
            $display("FAIL bp_w1: got p%0d a%h d%h", wq[1].port,
                     wq[1].addr, wq[1].data);
        end
        checks++;
        if (wq[2].port !== 2'd1 || wq[2].addr !== 16'h0102 ||
            wq[2].data !== 144'h1000000C_1000000B_1000000A_10000009) begin
            errors++;
            $display("FAIL bp_w2: got p%0d a%h d%h", wq[2].port,
                     wq[2].addr, wq[2].data);
        end
        checks++;
        if (rdy_viol != 0) begin
            errors++;
            $display("FAIL bp_ready: got %0d violations expected 0",
                     rdy_viol);
        end
    endtask

    task automatic test_reserved();
        clear_q();
        send(32'hC000_0000);
        send(32'h0000_0000);
        for (int i = 1; i <= 4; i++) send(32'hDEAD_0000 + i);
        repeat (6) @(negedge clk);
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL rsv_quiet: got %0d writes %0d dones expected 0 0",
                     wq.size(), dq.size());
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rsv_err: got %b expected 1", err);
        end
        send(32'h0000_0020);
        send(32'h0000_0000);
        send(32'h11); send(32'h22); send(32'h33); send(32'h44);
        wait_done(1);
        checks++;
        if (wq.size() != 1 || wq[0].port !== 2'd0 ||
            wq[0].addr !== 16'h0020 ||
            wq[0].data !== 144'h00000044_00000033_00000022_00000011) begin
            errors++;
            $display("FAIL rsv_next: got n=%0d a%h d%h expected a0020",
                     wq.size(), wq[0].addr, wq[0].data);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rsv_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send(32'h4000_0050);
        send(32'h0000_0000);
        send(32'hAAAA_0001);
        send(32'hAAAA_0002);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ld_mem, ld_mem2, ld_rom, done, err, busy,
             sif.s_ready_o} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_flags: got %b expected 0000000",
                     {ld_mem, ld_mem2, ld_rom, done, err, busy,
                      sif.s_ready_o});
        end
        checks++;
        if ({a_mem, a_mem2, a_rom, d_mem, d_mem2, d_rom} !== 437'h0) begin
            errors++;
            $display("FAIL midrst_bus: nonzero address/data outputs");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        send(32'h0000_0003);
        send(32'h0000_0000);
        send(32'hA); send(32'hB); send(32'hC); send(32'hD);
        wait_done(1);
        checks++;
        if (wq.size() != 1 || wq[0].port !== 2'd0 ||
            wq[0].addr !== 16'h0003 ||
            wq[0].data !== 144'h0000000D_0000000C_0000000B_0000000A) begin
            errors++;
            $display("FAIL midrst_next: got n=%0d p%0d a%h d%h expected a0003",
                     wq.size(), wq[0].port, wq[0].addr, wq[0].data);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        busy_low = 0;
        send(32'h0000_0040);
        busy_chk = 1;
        send(32'h0000_0000);
        for (int i = 1; i <= 4; i++) send(i);
        send(32'h4000_0041);
        send(32'h0000_0000);
        for (int i = 5; i <= 8; i++) send(i);
        busy_chk = 0;
        wait_done(2);
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", wq.size());
        end
        checks++;
        if (wq[0].port !== 2'd0 || wq[0].addr !== 16'h0040 ||
            wq[0].data !== 144'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL b2b_feat: got p%0d a%h d%h", wq[0].port,
                     wq[0].addr, wq[0].data);
        end
        checks++;
        if (wq[1].port !== 2'd1 || wq[1].addr !== 16'h0041 ||
            wq[1].data !== 144'h00000008_00000007_00000006_00000005) begin
            errors++;
            $display("FAIL b2b_wgt: got p%0d a%h d%h", wq[1].port,
                     wq[1].addr, wq[1].data);
        end
        checks++;
        if (busy_low != 0 || dq.size() != 2) begin
            errors++;
            $display("FAIL b2b_busy: got %0d idle %0d dones expected 0 2",
                     busy_low, dq.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sif.s_valid_i = 1'b0;
        sif.s_data_i  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_feature();
        test_rom();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
